// File: rtl/simple_bus_master_ctrl.sv
// simple_bus_master_ctrl
//   Initiator-side engine for the simple_bus protocol. Takes one read/write
//   command at a time from a CPU-side valid/ready port. It runs req/gnt
//   arbitration and the start/rdy transfer, then returns read data or a
//   timeout error on a valid/ready response port.
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_write/cmd_addr/cmd_wdata     command payload (1 = write)
//   rsp_valid/rsp_ready              response handshake
//   rsp_rdata/rsp_err                read data (0 for writes/errors), timeout flag
//   bus_req/bus_gnt                  arbitration
//   bus_addr/bus_mode/bus_start      transfer address, 00 read / 01 write, start strobe
//   bus_rdy                          slave completion
//   bus_data_out/oe/in               shared data bus
module simple_bus_master_ctrl #(
   parameter int unsigned AWIDTH  = 8,
   parameter int unsigned DWIDTH  = 8,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [AWIDTH-1:0] cmd_addr,
   input  logic [DWIDTH-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DWIDTH-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              bus_req,
   input  logic              bus_gnt,
   output logic [AWIDTH-1:0] bus_addr,
   output logic [1:0]        bus_mode,
   output logic              bus_start,
   input  logic              bus_rdy,
   output logic [DWIDTH-1:0] bus_data_out,
   output logic              bus_data_oe,
   input  logic [DWIDTH-1:0] bus_data_in
);

   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CntLast = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
   localparam logic [CW-1:0] CntMax  = '1;

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StArb   = 3'd1;
   localparam logic [2:0] StStart = 3'd2;
   localparam logic [2:0] StWait  = 3'd3;
   localparam logic [2:0] StResp  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic              write_q, write_d;
   logic [AWIDTH-1:0] addr_q, addr_d;
   logic [DWIDTH-1:0] wdata_q, wdata_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DWIDTH-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;

   // Output registers, loaded from the next state so they line up with it.
   logic              cmd_ready_q;
   logic              rsp_valid_q;
   logic              bus_req_q, bus_req_d;
   logic [AWIDTH-1:0] bus_addr_q, bus_addr_d;
   logic [1:0]        bus_mode_q, bus_mode_d;
   logic              bus_start_q;
   logic              oe_q, oe_d;
   logic [DWIDTH-1:0] dout_q, dout_d;

   always_comb begin
      state_d = state_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      case (state_q)
         StIdle: begin
            if (cmd_valid) begin
               write_d = cmd_write;
               addr_d  = cmd_addr;
               wdata_d = cmd_wdata;
               state_d = StArb;
            end
         end
         StArb: begin
            if (bus_gnt) state_d = StStart;
         end
         StStart: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            // rdy on the final allowed cycle still counts as success
            if (bus_rdy) begin
               rdata_d = write_q ? '0 : bus_data_in;
               err_d   = 1'b0;
               state_d = StResp;
            end else if ((TIMEOUT > 0) && (cnt_q == CntLast)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = StResp;
            end else if (cnt_q != CntMax) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus_req_d  = (state_d == StArb) || (state_d == StStart) || (state_d == StWait);
      bus_addr_d = bus_req_d ? addr_d : '0;
      bus_mode_d = bus_req_d ? {1'b0, write_d} : 2'b00;
      oe_d       = write_d && ((state_d == StStart) || (state_d == StWait));
      dout_d     = oe_d ? wdata_d : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         cmd_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         bus_req_q   <= 1'b0;
         bus_addr_q  <= '0;
         bus_mode_q  <= 2'b00;
         bus_start_q <= 1'b0;
         oe_q        <= 1'b0;
         dout_q      <= '0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         cmd_ready_q <= (state_d == StIdle);
         rsp_valid_q <= (state_d == StResp);
         bus_req_q   <= bus_req_d;
         bus_addr_q  <= bus_addr_d;
         bus_mode_q  <= bus_mode_d;
         bus_start_q <= (state_d == StStart);
         oe_q        <= oe_d;
         dout_q      <= dout_d;
      end
   end

   assign cmd_ready    = cmd_ready_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_rdata    = rdata_q;
   assign rsp_err      = err_q;
   assign bus_req      = bus_req_q;
   assign bus_addr     = bus_addr_q;
   assign bus_mode     = bus_mode_q;
   assign bus_start    = bus_start_q;
   assign bus_data_oe  = oe_q;
   assign bus_data_out = dout_q;

endmodule
